fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that drives the write port and read address of an external dual-port RAM (1 sync write, 1 async read) and exposes valid/ready push and pop interfaces.
- Owns the pointers, occupancy count, full/empty/almost-full flags and flush.
- RAM read data returns combinationally, so the pop side sees head data in the same cycle the read address is presented.

Parameters:
- DATA_WIDTH, 8, width of the FIFO entry and RAM word.
- DEPTH, 8, number of entries; power of two, >= 2; matches the attached RAM depth.
- ALMOST_FULL, 6, o_almost_full asserts when count >= ALMOST_FULL; legal range 1..DEPTH.
- AW is local, $clog2(DEPTH); CW is local, AW+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_flush  in  1  synchronous flush; empties FIFO
- i_push_valid  in  1  upstream has data
- o_push_ready  out  1  FIFO can accept; equals !full
- i_push_data  in  DATA_WIDTH  push payload
- o_pop_valid  out  1  head entry available; equals !empty
- i_pop_ready  in  1  downstream consumes head
- o_pop_data  out  DATA_WIDTH  head entry; equals i_ram_rd_data when o_pop_valid, else 0
- o_ram_wr_en  out  1  RAM write enable
- o_ram_wr_addr  out  AW  RAM write address (wr_ptr[AW-1:0])
- o_ram_wr_data  out  DATA_WIDTH  RAM write data (i_push_data)
- o_ram_rd_en  out  1  RAM read enable; equals o_pop_valid
- o_ram_rd_addr  out  AW  RAM read address (rd_ptr[AW-1:0])
- i_ram_rd_data  in  DATA_WIDTH  RAM async read data
- o_count  out  CW  occupancy, 0..DEPTH
- o_full  out  1  count == DEPTH
- o_empty  out  1  count == 0
- o_almost_full  out  1  count >= ALMOST_FULL

Behaviour:
- Reset: rst is asynchronous, active-high. While asserted, wr_ptr, rd_ptr and count are 0. Outputs: o_empty=1, o_full=0, o_almost_full=0, o_push_ready=1, o_pop_valid=0, o_ram_wr_en=0, o_count=0, o_pop_data=0.
- Pointers: wr_ptr and rd_ptr are CW bits wide and wrap naturally modulo 2*DEPTH.
  - full: MSBs differ and low AW bits are equal.
  - empty: pointers are equal.
  - count: wr_ptr - rd_ptr, mod 2^CW.
- Flags and count are derived from registered pointers only. There is no combinational path from i_pop_ready to o_push_ready, or from i_push_valid to o_pop_valid.
- Push fire: i_push_valid && o_push_ready. o_ram_wr_en equals push fire, combinationally. wr_ptr increments at that clk edge; the RAM captures the data at the same edge.
- Pop fire: o_pop_valid && i_pop_ready. rd_ptr increments at that clk edge. o_pop_data is valid during the fire cycle.
- Latency: a word pushed into an empty FIFO at edge N is visible on o_pop_data in the cycle after edge N. There is no write-to-read bypass.
- Simultaneous push and pop, non-empty and non-full: both fire and count is unchanged.
- Full with i_pop_ready=1: the pop fires and the push is refused (o_push_ready=0 that cycle). o_push_ready rises the next cycle.
- Empty with i_push_valid=1: the push fires, no pop occurs, and count becomes 1.
- Flush: i_flush=1 sets wr_ptr=rd_ptr=0 at the next edge and takes priority. Push and pop do not fire that cycle: o_push_ready and o_pop_valid are forced 0 and o_ram_wr_en=0. RAM contents are left stale.
- Reset mid-operation clears all state immediately. Stale RAM data is never presented, because o_pop_valid=0.
- Usage violations are illegal: i_push_data changing while valid and not ready, or i_pop_ready asserted while o_pop_valid=0.
  - An assertion fires on push-data instability.
  - Pop-ready while not valid is ignored.

Optional Feature:
- Macro: FIFO_CTRL_HIGH_WATER_EN.
- Defined: adds port o_high_water (out, CW), a register holding the maximum o_count observed since reset.
  - Updated each cycle as max(o_high_water, next count).
  - Cleared by rst only; i_flush does not clear it.
- Undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> o_empty=1, o_push_ready=1, o_pop_valid=0, o_count=0 immediately, without waiting for a clk edge.
- Fill then drain (DEPTH=8): push 0x10..0x17 with i_pop_ready=0.
  - After the 8th push: o_full=1, o_push_ready=0, o_count=8; o_almost_full=1 from count 6.
  - Then pop all 8 -> data 0x10..0x17 in order, o_empty=1.
- Wrap-around: 20 pushes and pops interleaved, count kept between 1 and 3 -> pointers wrap past 2*DEPTH, data order preserved, o_full never asserts.
- Full plus simultaneous pop: FIFO full, i_push_valid=1, i_pop_ready=1 for one cycle -> pop fires, push refused, o_count=7. Next cycle the push fires and o_count=8.
- Flush mid-stream: count=5, assert i_flush with push and pop requested -> no fire that cycle; next cycle o_count=0, o_empty=1; the next push is read back correctly.
- FIFO_CTRL_HIGH_WATER_EN: fill to 6, drain to 0, flush, fill to 3 -> o_high_water=6. After rst -> o_high_water=0.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller for an external dual-port RAM
// (one synchronous write port, one asynchronous read port).
// Owns the pointers, occupancy count, status flags and flush, and exposes
// valid/ready push and pop interfaces.
// Optional feature macro: FIFO_CTRL_HIGH_WATER_EN adds o_high_water, the peak
// occupancy seen since reset.
module fifo_ctrl #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ALMOST_FULL = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push_valid,
    output logic                       o_push_ready,
    input  logic [DATA_WIDTH-1:0]      i_push_data,
    output logic                       o_pop_valid,
    input  logic                       i_pop_ready,
    output logic [DATA_WIDTH-1:0]      o_pop_data,
    output logic                       o_ram_wr_en,
    output logic [$clog2(DEPTH)-1:0]   o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0]      o_ram_wr_data,
    output logic                       o_ram_rd_en,
    output logic [$clog2(DEPTH)-1:0]   o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]      i_ram_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_almost_full
`ifdef FIFO_CTRL_HIGH_WATER_EN
    ,
    output logic [$clog2(DEPTH):0]     o_high_water
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_c;
    logic          full_c;
    logic          empty_c;
    logic          push_ready_c;
    logic          pop_valid_c;
    logic          push_fire_c;
    logic          pop_fire_c;

    // Status derived from registered pointers only (extra pointer MSB tells full from empty)
    always_comb begin
        count_c = wr_ptr_q - rd_ptr_q;
        empty_c = (wr_ptr_q == rd_ptr_q);
        full_c  = (wr_ptr_q[CW-1] != rd_ptr_q[CW-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    // Handshakes; flush blocks both sides for the cycle it is asserted
    always_comb begin
        push_ready_c = !full_c && !i_flush;
        pop_valid_c  = !empty_c && !i_flush;
        push_fire_c  = i_push_valid && push_ready_c;
        pop_fire_c   = pop_valid_c && i_pop_ready;
    end

    // Next-state pointers; flush wins over push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_fire_c) begin
                wr_ptr_d = wr_ptr_q + CW'(1);
            end
            if (pop_fire_c) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
        end
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign o_push_ready  = push_ready_c;
    assign o_pop_valid   = pop_valid_c;
    assign o_pop_data    = pop_valid_c ? i_ram_rd_data : '0;
    assign o_ram_wr_en   = push_fire_c;
    assign o_ram_wr_addr = wr_ptr_q[AW-1:0];
    assign o_ram_wr_data = i_push_data;
    assign o_ram_rd_en   = pop_valid_c;
    assign o_ram_rd_addr = rd_ptr_q[AW-1:0];
    assign o_count       = count_c;
    assign o_full        = full_c;
    assign o_empty       = empty_c;
    assign o_almost_full = (count_c >= CW'(ALMOST_FULL));

`ifdef FIFO_CTRL_HIGH_WATER_EN
    logic [CW-1:0] high_water_q, high_water_d;
    logic [CW-1:0] count_d;

    // Peak tracker looks at the upcoming count; flush does not clear it
    always_comb begin
        count_d      = wr_ptr_d - rd_ptr_d;
        high_water_d = (count_d > high_water_q) ? count_d : high_water_q;
    end

    // High-water register, cleared by reset only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_water_q <= '0;
        end else begin
            high_water_q <= high_water_d;
        end
    end

    assign o_high_water = high_water_q;
`endif

    // A stalled push must hold its payload until accepted or withdrawn
    push_data_stable_a: assert property (
        @(posedge clk) disable iff (rst)
        (i_push_valid && !o_push_ready) |=> (!i_push_valid || $stable(i_push_data))
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: behavioural RAM, queue scoreboard and directed steps.
// Build with +define+FIFO_CTRL_HIGH_WATER_EN to also cover o_high_water.
module tb_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFULL = 6;

    logic          clk;
    logic          rst;
    logic          i_flush;
    logic          i_push_valid;
    logic          o_push_ready;
    logic [DW-1:0] i_push_data;
    logic          o_pop_valid;
    logic          i_pop_ready;
    logic [DW-1:0] o_pop_data;
    logic          o_ram_wr_en;
    logic [2:0]    o_ram_wr_addr;
    logic [DW-1:0] o_ram_wr_data;
    logic          o_ram_rd_en;
    logic [2:0]    o_ram_rd_addr;
    logic [DW-1:0] i_ram_rd_data;
    logic [3:0]    o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_almost_full;
`ifdef FIFO_CTRL_HIGH_WATER_EN
    logic [3:0]    o_high_water;
`endif

    fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL(AFULL)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (i_flush),
        .i_push_valid  (i_push_valid),
        .o_push_ready  (o_push_ready),
        .i_push_data   (i_push_data),
        .o_pop_valid   (o_pop_valid),
        .i_pop_ready   (i_pop_ready),
        .o_pop_data    (o_pop_data),
        .o_ram_wr_en   (o_ram_wr_en),
        .o_ram_wr_addr (o_ram_wr_addr),
        .o_ram_wr_data (o_ram_wr_data),
        .o_ram_rd_en   (o_ram_rd_en),
        .o_ram_rd_addr (o_ram_rd_addr),
        .i_ram_rd_data (i_ram_rd_data),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_almost_full (o_almost_full)
`ifdef FIFO_CTRL_HIGH_WATER_EN
        ,
        .o_high_water  (o_high_water)
`endif
    );

    // External RAM: synchronous write, asynchronous read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (o_ram_wr_en) mem[o_ram_wr_addr] <= o_ram_wr_data;
    end
    assign i_ram_rd_data = mem[o_ram_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    logic [DW-1:0] sb_q[$];
    int            m_wp;
    int            m_rp;
    int            m_hw;
    int            tests;
    int            fails;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_wp = 0;
        m_rp = 0;
        m_hw = 0;
    endtask

    // One clock cycle: drive, check against model, then advance model at the edge
    task automatic step(input logic pv, input logic [DW-1:0] pd,
                        input logic pr, input logic fl);
        int   cnt;
        logic exp_pr, exp_pv, pfire, qfire;
        i_push_valid = pv;
        i_push_data  = pd;
        i_pop_ready  = pr;
        i_flush      = fl;
        @(negedge clk);
        cnt    = sb_q.size();
        exp_pr = (cnt != DEPTH) && !fl;
        exp_pv = (cnt != 0) && !fl;
        pfire  = pv && exp_pr;
        qfire  = exp_pv && pr;
        chk("push_ready",  int'(o_push_ready),  int'(exp_pr));
        chk("pop_valid",   int'(o_pop_valid),   int'(exp_pv));
        chk("ram_rd_en",   int'(o_ram_rd_en),   int'(exp_pv));
        chk("ram_wr_en",   int'(o_ram_wr_en),   int'(pfire));
        chk("count",       int'(o_count),       cnt);
        chk("full",        int'(o_full),        int'(cnt == DEPTH));
        chk("empty",       int'(o_empty),       int'(cnt == 0));
        chk("almost_full", int'(o_almost_full), int'(cnt >= AFULL));
        chk("wr_addr",     int'(o_ram_wr_addr), m_wp % DEPTH);
        chk("rd_addr",     int'(o_ram_rd_addr), m_rp % DEPTH);
        if (pfire) chk("wr_data", int'(o_ram_wr_data), int'(pd));
        chk("pop_data", int'(o_pop_data), exp_pv ? int'(sb_q[0]) : 0);
`ifdef FIFO_CTRL_HIGH_WATER_EN
        chk("high_water", int'(o_high_water), m_hw);
`endif
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
            m_wp = 0;
            m_rp = 0;
        end else begin
            if (qfire) begin
                void'(sb_q.pop_front());
                m_rp = (m_rp + 1) % (2 * DEPTH);
            end
            if (pfire) begin
                sb_q.push_back(pd);
                m_wp = (m_wp + 1) % (2 * DEPTH);
            end
        end
        if (sb_q.size() > m_hw) m_hw = sb_q.size();
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_empty"},      int'(o_empty),       1);
        chk({tag, "_full"},       int'(o_full),        0);
        chk({tag, "_afull"},      int'(o_almost_full), 0);
        chk({tag, "_push_ready"}, int'(o_push_ready),  1);
        chk({tag, "_pop_valid"},  int'(o_pop_valid),   0);
        chk({tag, "_wr_en"},      int'(o_ram_wr_en),   0);
        chk({tag, "_count"},      int'(o_count),       0);
        chk({tag, "_pop_data"},   int'(o_pop_data),    0);
`ifdef FIFO_CTRL_HIGH_WATER_EN
        chk({tag, "_high_water"}, int'(o_high_water),  0);
`endif
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        i_flush      = 1'b0;
        i_push_valid = 1'b0;
        i_push_data  = '0;
        i_pop_ready  = 1'b0;
        model_reset();
        #2;
        chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle and pop-ready on empty: ignored
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill 0x10..0x17 then drain in order
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Wrap-around with count held between 1 and 3
        step(1'b1, 8'h80, 1'b0, 1'b0);
        step(1'b1, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Full with simultaneous push and pop: pop fires, push waits one cycle
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush mid-stream at count 5 with push and pop requested
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with data in flight
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        #2;
        i_push_valid = 1'b0;
        i_pop_ready  = 1'b0;
        rst          = 1'b1;
        #1;
        model_reset();
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // High-water sequence: fill 6, drain, flush, fill 3
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef FIFO_CTRL_HIGH_WATER_EN
        chk("hw_peak", int'(o_high_water), 6);
`endif
        rst = 1'b1;
        #1;
        model_reset();
        chk_reset_outputs("final_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
